rl_ram_nr1w: RTL and testbench



---
 rtl/rl_ram_pkg.sv | 21 ++
 rtl/rl_ram_nr1w_bank.sv | 48 ++++
 rtl/rl_ram_nr1w.sv | 160 ++++++++++++++++
 tb/tb_rl_ram_nr1w.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rl_ram_pkg.sv
// Shared types, constants and helpers for the multi-read-port RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rl_ram_pkg;

    // Clear sequencer states.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_t;

    // Read-during-write result selection.
    localparam string RDW_NEW_DATA = "NEW_DATA";
    localparam string RDW_OLD_DATA = "OLD_DATA";

    // Number of byte enables for a data word; the top one may cover fewer than 8 bits.
    function automatic int be_width(input int dbits);
        return (dbits + 7) / 8;
    endfunction

endpackage

// File: rtl/rl_ram_nr1w_bank.sv
// One 1R1W read-first storage bank with byte-enabled write and registered read.
// Latency: read data appears one cycle after re.
// Backpressure: none; one read and one write are accepted every cycle.
module rl_ram_nr1w_bank
    import rl_ram_pkg::*;
#(
    parameter int    ABITS      = 10,
    parameter int    DBITS      = 32,
    parameter string TECHNOLOGY = "GENERIC"
) (
    input  logic                       clk_i,
    input  logic                       we,
    input  logic [ABITS-1:0]           waddr,
    input  logic [DBITS-1:0]           din,
    input  logic [be_width(DBITS)-1:0] be,
    input  logic                       re,
    input  logic [ABITS-1:0]           raddr,
    output logic [DBITS-1:0]           rdat
);
    localparam int DEPTH = 1 << ABITS;

    // Per-bit write mask; bits above the last full byte follow the top enable.
    logic [DBITS-1:0] wmask;
    for (genvar i = 0; i < DBITS; i++) begin : g_mask
        assign wmask[i] = be[i / 8];
    end

    if (TECHNOLOGY == "GENERIC") begin : g_generic
        logic [DBITS-1:0] mem [DEPTH];

        // Read-first: the read samples the word before this edge's write lands.
        always_ff @(posedge clk_i) begin
            if (we) mem[waddr] <= (mem[waddr] & ~wmask) | (din & wmask);
            if (re) rdat <= mem[raddr];
        end
    end else begin : g_macro
        // Vendor macros are wrapped here; with no macro for the requested
        // technology the inferred array keeps the bank functional.
        logic [DBITS-1:0] mem [DEPTH];

        // Read-first array, same behaviour as the generic path.
        always_ff @(posedge clk_i) begin
            if (we) mem[waddr] <= (mem[waddr] & ~wmask) | (din & wmask);
            if (re) rdat <= mem[raddr];
        end
    end

endmodule

// File: rtl/rl_ram_nr1w.sv
// N-read/1-write RAM: one bank per read port, byte-merged RDW bypass, post-reset clear.
// Latency: read data one cycle after re_i (two with OUT_REG = 1).
// Backpressure: busy_o high during the clear sequence; all accesses are dropped then.
module rl_ram_nr1w
    import rl_ram_pkg::*;
#(
    parameter int    ABITS      = 10,
    parameter int    DBITS      = 32,
    parameter int    RPORTS     = 2,
    parameter string RDW_MODE   = RDW_NEW_DATA,
    parameter int    OUT_REG    = 0,
    parameter int    INIT_CLEAR = 1,
    parameter string TECHNOLOGY = "GENERIC"
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [ABITS-1:0]           waddr_i,
    input  logic [DBITS-1:0]           din_i,
    input  logic                       we_i,
    input  logic [be_width(DBITS)-1:0] be_i,
    input  logic [RPORTS*ABITS-1:0]    raddr_i,
    input  logic [RPORTS-1:0]          re_i,
    output logic [RPORTS*DBITS-1:0]    dout_o,
    output logic [RPORTS-1:0]          dvalid_o,
    output logic                       busy_o
);
    localparam int         BEW       = be_width(DBITS);
    localparam bit         USE_NEW   = (RDW_MODE != RDW_OLD_DATA);
    localparam ram_state_t RST_STATE = (INIT_CLEAR != 0) ? CLEAR : READY;

    ram_state_t       state_q, state_d;
    logic [ABITS-1:0] clr_cnt_q, clr_cnt_d;
    logic             ready;

    logic             bank_we;
    logic [ABITS-1:0] bank_waddr;
    logic [DBITS-1:0] bank_din;
    logic [BEW-1:0]   bank_be;

    logic [RPORTS-1:0] bank_re, rd_hit, rd_vld_q, hit_q;
    logic [DBITS-1:0]  din_q, byp_mask;
    logic [BEW-1:0]    be_q;

    assign ready  = (state_q == READY);
    assign busy_o = (state_q == CLEAR);

    // Clear sequencer state and address counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Walk every address once, leave CLEAR after the last word is zeroed.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (&clr_cnt_q) state_d = READY;
        end
    end

    // Write port mux: clear sequencer owns the banks while busy, the user otherwise.
    always_comb begin
        bank_we    = 1'b0;
        bank_waddr = waddr_i;
        bank_din   = din_i;
        bank_be    = be_i;
        if (state_q == CLEAR) begin
            bank_we    = rst_ni;
            bank_waddr = clr_cnt_q;
            bank_din   = '0;
            bank_be    = '1;
        end else begin
            bank_we    = rst_ni & we_i;
        end
    end

    // Read strobe and read-during-write hit flags, one per port.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_vld_q <= '0;
            hit_q    <= '0;
        end else begin
            rd_vld_q <= bank_re;
            hit_q    <= rd_hit;
        end
    end

    // Write data and enables kept one cycle for the bypass merge; shared by all ports.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            din_q <= '0;
            be_q  <= '0;
        end else if (ready && we_i) begin
            din_q <= din_i;
            be_q  <= be_i;
        end
    end

    for (genvar i = 0; i < DBITS; i++) begin : g_byp_mask
        assign byp_mask[i] = be_q[i / 8];
    end

    for (genvar p = 0; p < RPORTS; p++) begin : g_port
        logic [DBITS-1:0] rd_dat, merged, out_q;

        assign bank_re[p] = ready & re_i[p];
        assign rd_hit[p]  = bank_re[p] & we_i & (raddr_i[p*ABITS +: ABITS] == waddr_i);

        rl_ram_nr1w_bank #(
            .ABITS      (ABITS),
            .DBITS      (DBITS),
            .TECHNOLOGY (TECHNOLOGY)
        ) u_bank (
            .clk_i (clk_i),
            .we    (bank_we),
            .waddr (bank_waddr),
            .din   (bank_din),
            .be    (bank_be),
            .re    (bank_re[p]),
            .raddr (raddr_i[p*ABITS +: ABITS]),
            .rdat  (rd_dat)
        );

        // Banks return the pre-write word; overlay the bytes written alongside the read.
        always_comb begin
            merged = rd_dat;
            if (USE_NEW && hit_q[p]) merged = (din_q & byp_mask) | (rd_dat & ~byp_mask);
        end

        // Last delivered word, so an idle port keeps showing it.
        always_ff @(posedge clk_i) begin
            if (!rst_ni)         out_q <= '0;
            else if (rd_vld_q[p]) out_q <= merged;
        end

        if (OUT_REG != 0) begin : g_oreg
            logic dv_q;

            // Valid follows the registered data stage.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) dv_q <= 1'b0;
                else         dv_q <= rd_vld_q[p];
            end

            assign dout_o[p*DBITS +: DBITS] = out_q;
            assign dvalid_o[p]              = dv_q;
        end else begin : g_comb
            assign dout_o[p*DBITS +: DBITS] = rd_vld_q[p] ? merged : out_q;
            assign dvalid_o[p]              = rd_vld_q[p];
        end
    end

endmodule

// File: tb/tb_rl_ram_nr1w.sv
// Bench for rl_ram_nr1w: NEW_DATA and OLD_DATA 2-port instances plus a 20-bit OUT_REG instance.
// Latency: reads are scored against the cycle they are due on.
// Backpressure: n/a.
module tb_rl_ram_nr1w;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni;
    logic [3:0]  waddr;
    logic [31:0] din;
    logic        we;
    logic [3:0]  be;
    logic [7:0]  raddr;
    logic [1:0]  re;
    logic [63:0] dout_a, dout_b;
    logic [1:0]  dv_a, dv_b;
    logic        busy_a, busy_b;

    logic [3:0]  c_waddr, c_raddr;
    logic [19:0] c_din, c_dout;
    logic        c_we, c_re, c_dv, c_busy;
    logic [2:0]  c_be;

    rl_ram_nr1w #(.ABITS(4), .DBITS(32), .RPORTS(2), .RDW_MODE("NEW_DATA"),
                  .OUT_REG(0), .INIT_CLEAR(1), .TECHNOLOGY("GENERIC")) u_new (
        .clk_i(clk), .rst_ni(rst_ni), .waddr_i(waddr), .din_i(din), .we_i(we), .be_i(be),
        .raddr_i(raddr), .re_i(re), .dout_o(dout_a), .dvalid_o(dv_a), .busy_o(busy_a));

    rl_ram_nr1w #(.ABITS(4), .DBITS(32), .RPORTS(2), .RDW_MODE("OLD_DATA"),
                  .OUT_REG(0), .INIT_CLEAR(1), .TECHNOLOGY("GENERIC")) u_old (
        .clk_i(clk), .rst_ni(rst_ni), .waddr_i(waddr), .din_i(din), .we_i(we), .be_i(be),
        .raddr_i(raddr), .re_i(re), .dout_o(dout_b), .dvalid_o(dv_b), .busy_o(busy_b));

    rl_ram_nr1w #(.ABITS(4), .DBITS(20), .RPORTS(1), .RDW_MODE("NEW_DATA"),
                  .OUT_REG(1), .INIT_CLEAR(0), .TECHNOLOGY("GENERIC")) u_oreg (
        .clk_i(clk), .rst_ni(rst_ni), .waddr_i(c_waddr), .din_i(c_din), .we_i(c_we), .be_i(c_be),
        .raddr_i(c_raddr), .re_i(c_re), .dout_o(c_dout), .dvalid_o(c_dv), .busy_o(c_busy));

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic        we;
        logic [3:0]  waddr;
        logic [31:0] din;
        logic [3:0]  be;
        logic [1:0]  re;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [31:0] ea0;
        logic [31:0] ea1;
        logic [31:0] eb0;
        logic [31:0] eb1;
    } vec_t;

    // Channels: 0/1 = new-data ports, 2/3 = old-data ports, 4 = out-reg port.
    exp_t sbq [5][$];
    vec_t vt [12];
    int   nvec = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] d, input int lat);
        exp_t e;
        e.data = d;
        e.due  = cyc + lat;
        sbq[k].push_back(e);
    endtask

    // Advance one cycle and score every channel on the falling edge.
    task automatic tick();
        logic [31:0] ad [5];
        logic        av [5];
        exp_t        e;
        @(negedge clk);
        cyc++;
        ad[0] = dout_a[31:0];  av[0] = dv_a[0];
        ad[1] = dout_a[63:32]; av[1] = dv_a[1];
        ad[2] = dout_b[31:0];  av[2] = dv_b[0];
        ad[3] = dout_b[63:32]; av[3] = dv_b[1];
        ad[4] = {12'h000, c_dout}; av[4] = c_dv;
        for (int k = 0; k < 5; k++) begin
            if (sbq[k].size() != 0 && sbq[k][0].due == cyc) begin
                e = sbq[k].pop_front();
                nvec++;
                if (!av[k] || ad[k] !== e.data) begin
                    nfail++;
                    $display("FAIL read ch%0d cyc %0d: dvalid=%0b data=%h, want dvalid=1 data=%h",
                             k, cyc, av[k], ad[k], e.data);
                end
            end else if (av[k]) begin
                nvec++;
                nfail++;
                $display("FAIL stray dvalid ch%0d cyc %0d: got 1, want 0", k, cyc);
            end
        end
    endtask

    task automatic wait_clear(input string name);
        n = 0;
        while (busy_a && n < 100) begin
            n++;
            tick();
            if (busy_a) chk({name, " dvalid while busy"}, {28'h0, dv_b, dv_a}, 32'h0);
        end
        re = 2'b00;
        chk(name, n, 32'd16);
        chk({name, " busy_b"}, {31'h0, busy_b}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 4'hF, 2'b00, 4'd0,  4'd0,  32'h0, 32'h0, 32'h0, 32'h0};
        vt[1]  = '{1'b1, 4'd9,  32'h12345678, 4'hF, 2'b00, 4'd0,  4'd0,  32'h0, 32'h0, 32'h0, 32'h0};
        vt[2]  = '{1'b0, 4'd0,  32'h0,        4'h0, 2'b11, 4'd3,  4'd9,
                   32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
        vt[3]  = '{1'b1, 4'd5,  32'hAABBCCDD, 4'hF, 2'b00, 4'd0,  4'd0,  32'h0, 32'h0, 32'h0, 32'h0};
        vt[4]  = '{1'b1, 4'd5,  32'h11223344, 4'h5, 2'b11, 4'd5,  4'd5,
                   32'hAA22CC44, 32'hAA22CC44, 32'hAABBCCDD, 32'hAABBCCDD};
        vt[5]  = '{1'b0, 4'd0,  32'h0,        4'h0, 2'b11, 4'd5,  4'd3,
                   32'hAA22CC44, 32'hDEADBEEF, 32'hAA22CC44, 32'hDEADBEEF};
        vt[6]  = '{1'b1, 4'd3,  32'hFFFFFFFF, 4'h0, 2'b10, 4'd0,  4'd3,
                   32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        vt[7]  = '{1'b0, 4'd0,  32'h0,        4'h0, 2'b01, 4'd3,  4'd0,
                   32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        vt[8]  = '{1'b1, 4'd9,  32'hCAFEF00D, 4'h8, 2'b11, 4'd9,  4'd3,
                   32'hCA345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
        vt[9]  = '{1'b1, 4'd12, 32'h01020304, 4'hF, 2'b01, 4'd12, 4'd0,
                   32'h01020304, 32'h0, 32'h00000000, 32'h0};
        vt[10] = '{1'b0, 4'd0,  32'h0,        4'h0, 2'b11, 4'd9,  4'd12,
                   32'hCA345678, 32'h01020304, 32'hCA345678, 32'h01020304};
        vt[11] = '{1'b1, 4'd0,  32'h55555555, 4'h3, 2'b10, 4'd0,  4'd0,
                   32'h0, 32'h00005555, 32'h0, 32'h00000000};

        rst_ni = 1'b0; we = 1'b0; waddr = '0; din = '0; be = '0; re = '0; raddr = '0;
        c_we = 1'b0; c_waddr = '0; c_din = '0; c_be = '0; c_re = 1'b0; c_raddr = '0;
        tick();
        tick();
        chk("rst busy_a", {31'h0, busy_a}, 32'h1);
        chk("rst busy_c", {31'h0, c_busy}, 32'h0);
        chk("rst dvalid", {27'h0, c_dv, dv_b, dv_a}, 32'h0);
        chk("rst dout_a0", dout_a[31:0], 32'h0);
        chk("rst dout_a1", dout_a[63:32], 32'h0);
        chk("rst dout_c", {12'h0, c_dout}, 32'h0);

        // Release reset with reads requested; they must all be ignored while clearing.
        rst_ni = 1'b1;
        re = 2'b11;
        raddr = 8'h21;
        wait_clear("clear_len");

        // 20-bit out-reg instance: partial top byte, bypass merge and two-cycle latency.
        c_we = 1'b1; c_waddr = 4'd2; c_din = 20'hABCDE; c_be = 3'b111; tick();
        c_din = 20'h12345; c_be = 3'b100; tick();
        c_waddr = 4'd4; c_din = 20'hFFFFF; c_be = 3'b111; tick();
        c_din = 20'h00000; c_be = 3'b010; c_re = 1'b1; c_raddr = 4'd4;
        push(4, 32'h000F00FF, 2); tick();
        c_we = 1'b0; c_raddr = 4'd2;
        push(4, 32'h0001BCDE, 2); tick();
        c_re = 1'b0;
        repeat (4) tick();
        chk("oreg hold dout", {12'h0, c_dout}, 32'h0001BCDE);
        chk("oreg hold dvalid", {31'h0, c_dv}, 32'h0);

        // Vector table on both 32-bit instances.
        for (int i = 0; i < 12; i++) begin
            we = vt[i].we; waddr = vt[i].waddr; din = vt[i].din; be = vt[i].be;
            re = vt[i].re; raddr = {vt[i].ra1, vt[i].ra0};
            if (vt[i].re[0]) begin push(0, vt[i].ea0, 1); push(2, vt[i].eb0, 1); end
            if (vt[i].re[1]) begin push(1, vt[i].ea1, 1); push(3, vt[i].eb1, 1); end
            tick();
        end
        we = 1'b0; re = 2'b00;
        tick();
        tick();
        chk("hold a0", dout_a[31:0], 32'hCA345678);
        chk("hold a1", dout_a[63:32], 32'h00005555);
        chk("hold b0", dout_b[31:0], 32'hCA345678);
        chk("hold b1", dout_b[63:32], 32'h00000000);

        // Reset mid-clear: clearing restarts and runs the full length again.
        rst_ni = 1'b0; tick(); rst_ni = 1'b1;
        repeat (7) tick();
        chk("busy at clear cycle 7", {31'h0, busy_a}, 32'h1);
        rst_ni = 1'b0; tick(); rst_ni = 1'b1;
        wait_clear("clear_len_restart");

        for (int i = 0; i < 16; i++) begin
            re = 2'b11;
            raddr = {4'(15 - i), 4'(i)};
            for (int k = 0; k < 4; k++) push(k, 32'h0, 1);
            tick();
        end
        re = 2'b00;
        // Reset alone never clears the INIT_CLEAR=0 instance.
        c_re = 1'b1; c_raddr = 4'd2;
        push(4, 32'h0001BCDE, 2); tick();
        c_re = 1'b0;
        repeat (3) tick();

        for (int k = 0; k < 5; k++) chk($sformatf("drained ch%0d", k), sbq[k].size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
